// File: rtl/shift_seq.sv
// shift_seq: iterative WIDTH-bit shift/rotate unit with a start/busy/done handshake.
// Optional overflow flag enabled by defining SHIFT_SEQ_OVERFLOW_EN.

package shifterPkg;
    typedef enum logic [2:0] {
        SHL = 3'd0,
        SHR = 3'd1,
        SAR = 3'd2,
        ROL = 3'd3,
        ROR = 3'd4,
        RCL = 3'd5,
        RCR = 3'd6
    } shiftOpSel;
endpackage

// state    | meaning
// S_IDLE   | waiting for start
// S_RUN    | applying up to STEP single-bit shifts per cycle
// S_FIN    | result presented, done pulse
module shift_seq
    import shifterPkg::*;
#(
    parameter int WIDTH = 32,
    parameter int STEP  = 4,
    parameter int CW    = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  shiftOpSel        shiftOp,
    input  logic [CW-1:0]    count,
    input  logic             carryIn,
    input  logic [WIDTH-1:0] dataIn,
    output logic             busy,
    output logic             done,
    output logic             carryOut,
`ifdef SHIFT_SEQ_OVERFLOW_EN
    output logic             overflow,
`endif
    output logic [WIDTH-1:0] dataOut
);

    localparam int RW = CW + 1;
    localparam logic [RW-1:0] STEP_R = RW'(STEP);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIN  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    shiftOpSel          op_q;
    logic [CW-1:0]      rem_q;
    logic [WIDTH-1:0]   data_q;
    logic               carry_q;
    logic [WIDTH-1:0]   dataOut_q;
    logic               carryOut_q;

    logic               accept;
    logic               op_ok;
    logic [RW-1:0]      rem_ext;
    logic [RW-1:0]      n_step;
    logic [RW-1:0]      rem_nx;
    logic [WIDTH-1:0]   stg_data  [STEP+1];
    logic               stg_carry [STEP+1];
    logic [WIDTH-1:0]   fin_data;
    logic               fin_carry;

    // Returns {carry, data} after one single-bit step.
    function automatic logic [WIDTH:0] shift1(shiftOpSel op, logic [WIDTH-1:0] d, logic c);
        logic [WIDTH:0] r;
        case (op)
            SHL:     r = {d[WIDTH-1], d[WIDTH-2:0], 1'b0};
            SHR:     r = {d[0], 1'b0, d[WIDTH-1:1]};
            SAR:     r = {d[0], d[WIDTH-1], d[WIDTH-1:1]};
            ROL:     r = {d[WIDTH-1], d[WIDTH-2:0], d[WIDTH-1]};
            ROR:     r = {d[0], d[0], d[WIDTH-1:1]};
            RCL:     r = {d[WIDTH-1], d[WIDTH-2:0], c};
            RCR:     r = {d[0], c, d[WIDTH-1:1]};
            default: r = {c, d};
        endcase
        return r;
    endfunction

    always_comb begin
        op_ok = 1'b0;
        case (shiftOp)
            SHL, SHR, SAR, ROL, ROR, RCL, RCR: op_ok = 1'b1;
            default:                           op_ok = 1'b0;
        endcase
    end

    assign accept  = (state_q == S_IDLE) && start;
    assign rem_ext = {1'b0, rem_q};
    assign n_step  = (rem_ext > STEP_R) ? STEP_R : rem_ext;
    assign rem_nx  = rem_ext - n_step;

    // Stage i shifts only while i < remaining, so the last cycle may be partial.
    always_comb begin
        stg_data[0]  = data_q;
        stg_carry[0] = carry_q;
        for (int i = 0; i < STEP; i++) begin
            if (RW'(i) < rem_ext) begin
                {stg_carry[i+1], stg_data[i+1]} = shift1(op_q, stg_data[i], stg_carry[i]);
            end else begin
                stg_carry[i+1] = stg_carry[i];
                stg_data[i+1]  = stg_data[i];
            end
        end
    end

    // Entering FIN straight from IDLE means a zero count or an undefined opcode.
    assign fin_data  = (state_q == S_RUN) ? stg_data[STEP]  : dataIn;
    assign fin_carry = (state_q == S_RUN) ? stg_carry[STEP] : carryIn;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = (op_ok && (count != '0)) ? S_RUN : S_FIN;
                end
            end
            S_RUN: begin
                if (rem_nx == '0) begin
                    state_d = S_FIN;
                end
            end
            S_FIN:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        busy = (state_q != S_IDLE);
        done = (state_q == S_FIN);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            op_q       <= SHL;
            rem_q      <= '0;
            data_q     <= '0;
            carry_q    <= 1'b0;
            dataOut_q  <= '0;
            carryOut_q <= 1'b0;
        end else begin
            if (accept) begin
                op_q    <= shiftOp;
                rem_q   <= op_ok ? count : '0;
                data_q  <= dataIn;
                carry_q <= carryIn;
            end else if (state_q == S_RUN) begin
                data_q  <= stg_data[STEP];
                carry_q <= stg_carry[STEP];
                rem_q   <= rem_nx[CW-1:0];
            end
            if (state_d == S_FIN) begin
                dataOut_q  <= fin_data;
                carryOut_q <= fin_carry;
            end
        end
    end

    assign dataOut  = dataOut_q;
    assign carryOut = carryOut_q;

`ifdef SHIFT_SEQ_OVERFLOW_EN
    logic cnt1_q;
    logic dmsb_q;
    logic ovf_q;
    logic ovf_d;

    always_comb begin
        ovf_d = 1'b0;
        if ((state_q == S_RUN) && cnt1_q) begin
            case (op_q)
                SHL, ROL, RCL: ovf_d = fin_data[WIDTH-1] ^ fin_carry;
                SHR:           ovf_d = dmsb_q;
                ROR, RCR:      ovf_d = fin_data[WIDTH-1] ^ fin_data[WIDTH-2];
                default:       ovf_d = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt1_q <= 1'b0;
            dmsb_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            if (accept) begin
                cnt1_q <= (count == CW'(1));
                dmsb_q <= dataIn[WIDTH-1];
            end
            if (state_d == S_FIN) begin
                ovf_q <= ovf_d;
            end
        end
    end

    assign overflow = ovf_q;
`endif

endmodule
